addr_seq: RTL and testbench



---
 rtl/addr_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_addr_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_seq.sv
// addr_seq: 6502 effective-address sequencer. Walks operand fetch, zero-page
// and indirect pointer reads, index add and page-cross fix-up, then the
// effective-address access (plus write-back cycles for read-modify-write).
// Ports: start/op_type/mem_rd/mem_wr/idx_XY from the decoder; pc_i, x_i, y_i
// from the register file; data_i/addr_o/rd_o/wr_o form the memory bus;
// pc_inc_o, ea_o, operand_o/operand_valid_o, busy_o, done_o, unsupported_o
// report back to the control unit and datapath.

package addr_seq_pkg;
  localparam logic [4:0] OP_IMP = 5'd0;
  localparam logic [4:0] OP_IMM = 5'd1;
  localparam logic [4:0] OP_ZPG = 5'd2;
  localparam logic [4:0] OP_ZXY = 5'd3;
  localparam logic [4:0] OP_ABS = 5'd4;
  localparam logic [4:0] OP_AXY = 5'd5;
  localparam logic [4:0] OP_XIN = 5'd6;
  localparam logic [4:0] OP_INY = 5'd7;
  localparam logic [4:0] OP_BRK = 5'd8;
  localparam logic [4:0] OP_JSR = 5'd9;
  localparam logic [4:0] OP_RTI = 5'd10;
  localparam logic [4:0] OP_RTS = 5'd11;
  localparam logic [4:0] OP_PUS = 5'd12;
  localparam logic [4:0] OP_PUL = 5'd13;
  localparam logic [4:0] OP_JUM = 5'd14;
  localparam logic [4:0] OP_JIN = 5'd15;
  localparam logic [4:0] OP_BRA = 5'd16;
  localparam logic [4:0] OP_JAM = 5'd17;
  localparam logic       IDX_X  = 1'b0;
  localparam logic       IDX_Y  = 1'b1;
endpackage

module addr_seq
  import addr_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  op_type,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        idx_XY,
  input  logic [15:0] pc_i,
  input  logic [7:0]  x_i,
  input  logic [7:0]  y_i,
  input  logic [7:0]  data_i,
  output logic [15:0] addr_o,
  output logic        rd_o,
  output logic        wr_o,
  output logic        pc_inc_o,
  output logic [15:0] ea_o,
  output logic [7:0]  operand_o,
  output logic        operand_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        unsupported_o
);

  typedef enum logic [3:0] {
    IDLE, OP1, OP2, ZDUM, PTRL, PTRH, FIX, DATA, RMWD, RMWW, DONE
  } state_t;

  state_t      state, nxt, prev_st;
  logic [4:0]  op_q;
  logic        rd_q, wr_q, idx_q, unsup_q, prev_rd;
  logic [7:0]  lo_q, hi_q, plo_q, phi_q, dat_q;
  logic [15:0] ea_q;

  function automatic logic is_mem_op(input logic [4:0] t);
    return (t == OP_ZPG) || (t == OP_ZXY) || (t == OP_ABS) ||
           (t == OP_AXY) || (t == OP_XIN) || (t == OP_INY);
  endfunction

  // Bytes arrive one cycle after their read, so the byte fetched by the
  // previous state is taken straight off data_i; afterwards its register.
  logic [7:0] lo_c, hi_c, plo_c, phi_c, idx;
  assign lo_c  = (prev_st == OP1)  ? data_i : lo_q;
  assign hi_c  = (prev_st == OP2)  ? data_i : hi_q;
  assign plo_c = (prev_st == PTRL) ? data_i : plo_q;
  assign phi_c = (prev_st == PTRH) ? data_i : phi_q;
  assign idx   = (idx_q == IDX_Y)  ? y_i : x_i;

  logic [7:0]  zp_idx, zp_x, zp_x1, zp_1;
  logic [8:0]  axy_sum, iny_sum;
  logic [15:0] ea_c;
  assign zp_idx  = lo_c + idx;           // zero-page wrap, no carry out
  assign zp_x    = lo_c + x_i;
  assign zp_x1   = zp_x + 8'd1;
  assign zp_1    = lo_c + 8'd1;
  assign axy_sum = {1'b0, lo_c} + {1'b0, idx};
  assign iny_sum = {1'b0, plo_c} + {1'b0, y_i};

  always_comb begin
    ea_c = {8'h00, lo_c};
    case (op_q)
      OP_ZXY:  ea_c = {8'h00, zp_idx};
      OP_ABS:  ea_c = {hi_c, lo_c};
      OP_AXY:  ea_c = {hi_c, lo_c} + {8'h00, idx};
      OP_XIN:  ea_c = {phi_c, plo_c};
      OP_INY:  ea_c = {phi_c, plo_c} + {8'h00, y_i};
      default: ea_c = {8'h00, lo_c};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev_st <= IDLE;
      op_q    <= OP_IMP;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= IDX_X;
      unsup_q <= 1'b0;
      prev_rd <= 1'b0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      plo_q   <= 8'h00;
      phi_q   <= 8'h00;
      dat_q   <= 8'h00;
      ea_q    <= 16'h0000;
    end else begin
      state   <= nxt;
      prev_st <= state;
      prev_rd <= rd_o;
      if (prev_rd)            dat_q <= data_i;
      if (prev_st == OP1)     lo_q  <= data_i;
      if (prev_st == OP2)     hi_q  <= data_i;
      if (prev_st == PTRL)    plo_q <= data_i;
      if (prev_st == PTRH)    phi_q <= data_i;
      if (state == DATA)      ea_q  <= ea_c;
      if (state == IDLE && start) begin
        op_q    <= op_type;
        rd_q    <= mem_rd;
        wr_q    <= mem_wr;
        idx_q   <= idx_XY;
        unsup_q <= !(is_mem_op(op_type) || op_type == OP_IMM || op_type == OP_IMP);
      end
    end
  end

  assign ea_o      = ea_q;
  // Last read byte is live on data_i the cycle after it, registered afterwards.
  assign operand_o = prev_rd ? data_i : dat_q;

  always_comb begin
    nxt             = state;
    addr_o          = pc_i;
    rd_o            = 1'b0;
    wr_o            = 1'b0;
    pc_inc_o        = 1'b0;
    busy_o          = 1'b1;
    done_o          = 1'b0;
    operand_valid_o = 1'b0;
    unsupported_o   = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start) nxt = (is_mem_op(op_type) || op_type == OP_IMM) ? OP1 : DONE;
      end
      OP1: begin
        rd_o     = 1'b1;
        pc_inc_o = 1'b1;
        case (op_q)
          OP_ZPG:         nxt = DATA;
          OP_ZXY, OP_XIN: nxt = ZDUM;
          OP_ABS, OP_AXY: nxt = OP2;
          OP_INY:         nxt = PTRL;
          default:        nxt = DONE;
        endcase
      end
      OP2: begin
        rd_o     = 1'b1;
        pc_inc_o = 1'b1;
        // Writes always take the fix-up slot so the store never hits a wrong page.
        nxt = (op_q == OP_AXY && (axy_sum[8] || wr_q)) ? FIX : DATA;
      end
      ZDUM: begin
        rd_o   = 1'b1;
        addr_o = {8'h00, lo_c};
        nxt    = (op_q == OP_XIN) ? PTRL : DATA;
      end
      PTRL: begin
        rd_o   = 1'b1;
        addr_o = (op_q == OP_XIN) ? {8'h00, zp_x} : {8'h00, lo_c};
        nxt    = PTRH;
      end
      PTRH: begin
        rd_o   = 1'b1;
        addr_o = (op_q == OP_XIN) ? {8'h00, zp_x1} : {8'h00, zp_1};
        nxt    = (op_q == OP_INY && (iny_sum[8] || wr_q)) ? FIX : DATA;
      end
      FIX: begin
        rd_o   = 1'b1;
        addr_o = (op_q == OP_INY) ? {phi_c, iny_sum[7:0]} : {hi_c, axy_sum[7:0]};
        nxt    = DATA;
      end
      DATA: begin
        addr_o = ea_c;
        rd_o   = rd_q;
        wr_o   = wr_q & !rd_q;
        nxt    = (rd_q && wr_q) ? RMWD : DONE;
      end
      RMWD: begin
        addr_o = ea_q;
        wr_o   = 1'b1;
        nxt    = RMWW;
      end
      RMWW: begin
        addr_o = ea_q;
        wr_o   = 1'b1;
        nxt    = DONE;
      end
      DONE: begin
        busy_o          = 1'b0;
        done_o          = 1'b1;
        unsupported_o   = unsup_q;
        operand_valid_o = !unsup_q && (op_q == OP_IMM || (is_mem_op(op_q) && rd_q));
        nxt             = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_addr_seq.sv
module tb_addr_seq;
  import addr_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  op_type;
  logic        mem_rd, mem_wr, idx_XY;
  logic [15:0] pc_i;
  logic [7:0]  x_i, y_i, data_i;
  logic [15:0] addr_o, ea_o;
  logic        rd_o, wr_o, pc_inc_o, operand_valid_o, busy_o, done_o, unsupported_o;
  logic [7:0]  operand_o;

  addr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_type(op_type),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .idx_XY(idx_XY), .pc_i(pc_i),
    .x_i(x_i), .y_i(y_i), .data_i(data_i), .addr_o(addr_o), .rd_o(rd_o),
    .wr_o(wr_o), .pc_inc_o(pc_inc_o), .ea_o(ea_o), .operand_o(operand_o),
    .operand_valid_o(operand_valid_o), .busy_o(busy_o), .done_o(done_o),
    .unsupported_o(unsupported_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic        r;
    logic        w;
    logic        i;
  } bus_t;

  typedef struct packed {
    int          lat;
    logic        uns;
    logic        opv;
    logic [7:0]  opd;
    logic        chk_ea;
    logic [15:0] ea;
  } done_t;

  logic [7:0] mem [0:65535];
  bus_t  bus_q[$];
  done_t done_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_nb;
  int    cyc = 0;
  bit    mon_en = 1'b1;
  logic        s_rd, s_inc;
  logic [15:0] s_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pushb(input logic [15:0] a, input logic r, input logic w, input logic i);
    bus_t b;
    b.a = a; b.r = r; b.w = w; b.i = i;
    bus_q.push_back(b);
    exp_nb++;
  endtask

  // Reference: expected bus cycles and completion for one instruction.
  task automatic expect_seq(input logic [4:0] op, input logic r, input logic w,
                            input logic iy, input logic [7:0] x, input logic [7:0] y,
                            input logic [15:0] pc);
    logic [7:0]  lo, hi, pl, ph, ix, z;
    logic [15:0] ea;
    logic        memop;
    done_t       d;
    exp_nb = 0;
    d      = '0;
    ea     = 16'h0000;
    ix     = iy ? y : x;
    lo     = mem[pc];
    hi     = mem[pc + 16'd1];
    memop  = op inside {OP_ZPG, OP_ZXY, OP_ABS, OP_AXY, OP_XIN, OP_INY};
    if (op == OP_IMM || memop) pushb(pc, 1'b1, 1'b0, 1'b1);
    case (op)
      OP_IMM: begin d.opv = 1'b1; d.opd = lo; end
      OP_ZPG: ea = {8'h00, lo};
      OP_ZXY: begin
        pushb({8'h00, lo}, 1'b1, 1'b0, 1'b0);
        z  = lo + ix;
        ea = {8'h00, z};
      end
      OP_ABS: begin
        pushb(pc + 16'd1, 1'b1, 1'b0, 1'b1);
        ea = {hi, lo};
      end
      OP_AXY: begin
        pushb(pc + 16'd1, 1'b1, 1'b0, 1'b1);
        ea = {hi, lo} + {8'h00, ix};
        if (ea[15:8] != hi || w) pushb({hi, ea[7:0]}, 1'b1, 1'b0, 1'b0);
      end
      OP_XIN: begin
        pushb({8'h00, lo}, 1'b1, 1'b0, 1'b0);
        z  = lo + x;
        pl = mem[{8'h00, z}];
        pushb({8'h00, z}, 1'b1, 1'b0, 1'b0);
        z  = z + 8'd1;
        ph = mem[{8'h00, z}];
        pushb({8'h00, z}, 1'b1, 1'b0, 1'b0);
        ea = {ph, pl};
      end
      OP_INY: begin
        pl = mem[{8'h00, lo}];
        pushb({8'h00, lo}, 1'b1, 1'b0, 1'b0);
        z  = lo + 8'd1;
        ph = mem[{8'h00, z}];
        pushb({8'h00, z}, 1'b1, 1'b0, 1'b0);
        ea = {ph, pl} + {8'h00, y};
        if (ea[15:8] != ph || w) pushb({ph, ea[7:0]}, 1'b1, 1'b0, 1'b0);
      end
      default: ;
    endcase
    if (memop) begin
      pushb(ea, r, w && !r, 1'b0);
      if (r && w) begin
        pushb(ea, 1'b0, 1'b1, 1'b0);
        pushb(ea, 1'b0, 1'b1, 1'b0);
      end
      d.opv = r; d.opd = mem[ea]; d.chk_ea = 1'b1; d.ea = ea;
    end
    d.uns = !(memop || op == OP_IMM || op == OP_IMP);
    d.lat = exp_nb + 1;
    done_q.push_back(d);
  endtask

  task automatic monitor();
    bus_t  b;
    done_t d;
    if (start && !busy_o && !done_o) cyc = 0; else cyc++;
    if (rd_o || wr_o || pc_inc_o) begin
      if (bus_q.size() == 0) chk("bus_extra", {rd_o, wr_o, pc_inc_o}, 32'd0);
      else begin
        b = bus_q.pop_front();
        chk("bus", {addr_o, rd_o, wr_o, pc_inc_o}, b);
        chk("busy_bus", busy_o, 1'b1);
      end
    end
    if (done_o) begin
      if (done_q.size() == 0) chk("done_extra", done_o, 1'b0);
      else begin
        d = done_q.pop_front();
        chk("latency", cyc, d.lat);
        chk("unsupported", unsupported_o, d.uns);
        chk("operand_valid", operand_valid_o, d.opv);
        chk("busy_done", busy_o, 1'b0);
        if (d.opv)    chk("operand", operand_o, d.opd);
        if (d.chk_ea) chk("ea", ea_o, d.ea);
      end
    end
  endtask

  // One clock: check outputs at the falling edge, then answer reads and
  // advance PC just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    s_rd = rd_o; s_addr = addr_o; s_inc = pc_inc_o;
    @(posedge clk);
    #1;
    data_i = s_rd ? mem[s_addr] : 8'hEE;
    if (s_inc) pc_i = pc_i + 16'd1;
  endtask

  task automatic do_op(input logic [4:0] op, input logic r, input logic w, input logic iy,
                       input logic [7:0] x, input logic [7:0] y, input logic [15:0] pc,
                       input bit repulse);
    int n;
    pc_i = pc; x_i = x; y_i = y;
    op_type = op; mem_rd = r; mem_wr = w; idx_XY = iy;
    expect_seq(op, r, w, iy, x, y, pc);
    start = 1'b1;
    tick();
    n = 0;
    while (done_q.size() > 0 && n < 30) begin
      start = repulse && (n == 1);
      if (repulse && n == 1) op_type = OP_IMM;
      tick();
      n++;
    end
    start = 1'b0;
    if (done_q.size() > 0) begin
      chk("timeout", done_q.size(), 32'd0);
      done_q.delete();
      bus_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0200] = 8'h5A;
    mem[16'h0300] = 8'hF0;
    mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h12;
    mem[16'h0410] = 8'hFF; mem[16'h0411] = 8'h12;
    mem[16'h0500] = 8'hFF; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0600] = 8'h00; mem[16'h0601] = 8'h40;
    mem[16'h0700] = 8'h80; mem[16'h0085] = 8'h78; mem[16'h0086] = 8'h56;
    mem[16'h0800] = 8'h33;
    mem[16'h0900] = 8'h10; mem[16'h0901] = 8'h20;
    mem[16'h0A00] = 8'h40; mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h21;
    mem[16'h0B00] = 8'h00; mem[16'h0B01] = 8'h50;

    rst_n = 1'b0; start = 1'b0; op_type = OP_IMP; mem_rd = 1'b0; mem_wr = 1'b0;
    idx_XY = IDX_X; pc_i = 16'h0300; x_i = 8'h00; y_i = 8'h00; data_i = 8'h00;
    tick();
    tick();
    chk("rst_rd", rd_o, 1'b0);
    chk("rst_wr", wr_o, 1'b0);
    chk("rst_pc_inc", pc_inc_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_opv", operand_valid_o, 1'b0);
    chk("rst_unsup", unsupported_o, 1'b0);
    chk("rst_ea", ea_o, 16'h0000);
    chk("rst_operand", operand_o, 8'h00);
    chk("rst_addr", addr_o, 16'h0300);
    rst_n = 1'b1;
    tick();

    do_op(OP_IMM, 1'b1, 1'b0, IDX_X, 8'h00, 8'h00, 16'h0200, 1'b0);
    do_op(OP_ZXY, 1'b1, 1'b0, IDX_X, 8'h20, 8'h00, 16'h0300, 1'b0);
    do_op(OP_AXY, 1'b1, 1'b0, IDX_Y, 8'h00, 8'h01, 16'h0400, 1'b0);
    do_op(OP_AXY, 1'b1, 1'b0, IDX_Y, 8'h77, 8'h00, 16'h0410, 1'b0);
    do_op(OP_INY, 1'b0, 1'b1, IDX_X, 8'h00, 8'h10, 16'h0500, 1'b0);
    do_op(OP_ABS, 1'b1, 1'b1, IDX_X, 8'h00, 8'h00, 16'h0600, 1'b0);
    do_op(OP_JSR, 1'b1, 1'b0, IDX_X, 8'h00, 8'h00, 16'h0650, 1'b0);
    do_op(OP_IMP, 1'b0, 1'b0, IDX_X, 8'h00, 8'h00, 16'h0660, 1'b0);
    do_op(OP_XIN, 1'b1, 1'b0, IDX_Y, 8'h05, 8'h99, 16'h0700, 1'b1);
    do_op(OP_ZPG, 1'b1, 1'b0, IDX_X, 8'h00, 8'h00, 16'h0800, 1'b0);
    do_op(OP_AXY, 1'b0, 1'b1, IDX_X, 8'h05, 8'h00, 16'h0900, 1'b0);
    do_op(OP_INY, 1'b1, 1'b0, IDX_X, 8'h00, 8'h20, 16'h0A00, 1'b0);
    do_op(OP_BRA, 1'b0, 1'b0, IDX_X, 8'h00, 8'h00, 16'h0A80, 1'b0);

    // ABS RMW to 0x5000, reset asserted during the first write-back cycle.
    mon_en = 1'b0;
    pc_i = 16'h0B00; op_type = OP_ABS; mem_rd = 1'b1; mem_wr = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("rmwd_wr", wr_o, 1'b1);
    chk("rmwd_addr", addr_o, 16'h5000);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr", wr_o, 1'b0);
    chk("rst_async_rd", rd_o, 1'b0);
    chk("rst_async_busy", busy_o, 1'b0);
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_done", done_o, 1'b0);
    end
    do_op(OP_ABS, 1'b1, 1'b0, IDX_X, 8'h00, 8'h00, 16'h0B00, 1'b0);

    chk("bus_left", bus_q.size(), 32'd0);
    chk("done_left", done_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
